// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues register read/write commands in a small FIFO and
// plays them one at a time into a level-triggered SPI master, returning one
// response per command.
// Optional watchdog: define SPI_SEQ_TIMEOUT_EN to abort commands whose done
// handshake never completes; without it err is tied low and no counter exists.
//
// Handshake: a command transfers on the rising clock edge where cmd_valid and
// cmd_ready are both high; cmd_valid while cmd_ready is low is ignored.
// rsp_valid is a one-cycle pulse with no backpressure.
module spi_cmd_sequencer #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          START_HOLD  = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       start_wr,
  output logic       start_re,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic       done,
  input  logic [7:0] rdata,
  output logic       rsp_valid,
  output logic       rsp_rw,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    HOLD = 4'(START_HOLD);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e state_q, state_d;

  // FIFO storage: {rw, addr, wdata}
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          push, pop;
  logic [16:0]   head;

  logic [3:0] hold_q, hold_d;
  logic       clr_q, clr_d;
  logic       start_wr_q, start_wr_d, start_re_q, start_re_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_rw_q, rsp_rw_d;
  logic [7:0] rsp_addr_q, rsp_addr_d, rsp_data_q, rsp_data_d;
  logic       busy_q, busy_d;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic        err_q, err_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign push = cmd_valid & ready_q;
  assign head = mem_q[rd_ptr_q];

  // FIFO payload write; contents need no reset since occupancy gates reads
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
  end

  // Occupancy bookkeeping; simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL);
  end

  // Sequencer next state and registered outputs
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    hold_d      = hold_q;
    clr_d       = clr_q;
    start_wr_d  = 1'b0;
    start_re_d  = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rw_d    = rsp_rw_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    to_d        = to_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          rsp_rw_d   = head[16];
          addr_d     = head[15:8];
          wdata_d    = head[7:0];
          rsp_addr_d = head[15:8];
          rsp_data_d = head[7:0];
          hold_d     = '0;
          clr_d      = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // A low done seen while the trigger is still held already counts
        clr_d = clr_q | ~done;
        if (hold_q != HOLD) begin
          hold_d     = hold_q + 4'd1;
          start_wr_d = rsp_rw_q;
          start_re_d = ~rsp_rw_q;
        end else begin
          state_d = WAIT_CLR;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        to_d = '0;
`endif
      end
      WAIT_CLR: begin
        if (clr_q || !done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          if (!rsp_rw_q) rsp_data_d = rdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog overrides a completion landing on the same cycle
    if (state_q == WAIT_CLR || state_q == WAIT_DONE) begin
      to_d = to_q + 16'd1;
      if (to_d == TIMEOUT_CYC) begin
        err_d       = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        state_d     = IDLE;
      end
    end
`endif
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  // State, FIFO pointers and output registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      hold_q      <= '0;
      clr_q       <= 1'b0;
      start_wr_q  <= 1'b0;
      start_re_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      ready_q     <= ready_d;
      hold_q      <= hold_d;
      clr_q       <= clr_d;
      start_wr_q  <= start_wr_d;
      start_re_q  <= start_re_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  // Watchdog counter and error pulse
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = ready_q;
  assign start_wr  = start_wr_q;
  assign start_re  = start_re_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rw    = rsp_rw_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer (default build, watchdog disabled).
// A behavioural SPI master drops done 3 cycles after seeing a start and raises
// it 60 cycles later with rdata = addr ^ 8'h68.
module tb_spi_cmd_sequencer;

  localparam int W = 25; // {rw, addr, wdata, expected rsp_data}

  logic       clock, n_reset;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       start_wr, start_re;
  logic [7:0] addr, wdata;
  logic       done;
  logic [7:0] rdata;
  logic       rsp_valid, rsp_rw;
  logic [7:0] rsp_addr, rsp_data;
  logic       busy, err;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int n_starts = 0;

  spi_cmd_sequencer dut (
    .clock(clock), .n_reset(n_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .start_wr(start_wr), .start_re(start_re), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [7:0] model_rdata(input logic [7:0] a);
    return a ^ 8'h68;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ctrl"}, {26'd0, cmd_ready, start_wr, start_re, rsp_valid, err, busy}, 32'b100000);
    check({tag, "_data"}, {7'd0, addr, wdata, rsp_addr, rsp_rw}, 32'd0);
    check({tag, "_rdata"}, {24'd0, rsp_data}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  // driver: offer one command, hold until accepted, record expectation
  task automatic push_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("push_accept", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) exp_q.push_back({rw, a, d, rw ? d : model_rdata(a)});
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain", {31'd0, (exp_q.size() == 0) && !busy}, 32'd1);
  endtask

  // SPI master model
  initial begin : master
    int m_state, cnt;
    logic [7:0] m_addr;
    m_state = 0; cnt = 0; m_addr = '0;
    done = 1'b1; rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (!n_reset) begin
        m_state = 0; cnt = 0; done = 1'b1;
      end else begin
        case (m_state)
          0: if (start_wr || start_re) begin m_state = 1; cnt = 0; m_addr = addr; end
          1: begin cnt++; if (cnt == 3) begin done = 1'b0; cnt = 0; m_state = 2; end end
          default: begin
            cnt++;
            if (cnt == 60) begin rdata = model_rdata(m_addr); done = 1'b1; m_state = 0; end
          end
        endcase
      end
    end
  end

  // scoreboard / monitor
  initial begin : monitor
    logic prev;
    int len;
    logic [W-1:0] e;
    prev = 1'b0; len = 0;
    forever begin
      @(negedge clock);
      if (!n_reset) begin
        prev = 1'b0; len = 0;
      end else begin
        if (start_wr || start_re) begin
          check("start_excl", {31'd0, start_wr & start_re}, 32'd0);
          if (!prev) begin
            n_starts++;
            len = 1;
            if (exp_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_q[0];
              check("start_kind", {30'd0, start_wr, start_re}, {30'd0, e[24], ~e[24]});
              check("start_addr", {16'd0, addr, wdata}, {16'd0, e[23:8]});
            end
          end else len++;
        end else if (prev) begin
          check("start_len", len, 32'd4);
        end
        prev = start_wr | start_re;
        if (rsp_valid) begin
          n_rsp++;
          if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("rsp", {15'd0, rsp_rw, rsp_addr, rsp_data}, {15'd0, e[24], e[23:16], e[7:0]});
          end
        end
      end
    end
  end

  // directed sequence
  initial begin : stim
    int n, starts_at_rst, rsp_at_rst;
    n_reset = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clock);
    reset_check("reset");
    n_reset = 1'b1;
    repeat (2) @(negedge clock);

    // single write with latency check
    push_cmd(1'b1, 8'h12, 8'hA5);
    @(posedge clock); #1;
    check("lat_edge_n1", {31'd0, start_wr}, 32'd0);
    @(posedge clock); #1;
    check("lat_edge_n2", {31'd0, start_wr}, 32'd1);
    wait_idle(500);

    // read, then fill the FIFO behind it
    push_cmd(1'b0, 8'h34, 8'h00);
    n = 0;
    while (!start_re && n < 50) begin @(negedge clock); n++; end
    check("rd_start_re", {31'd0, start_re}, 32'd1);
    check("rd_no_wr", {31'd0, start_wr}, 32'd0);
    push_cmd(1'b1, 8'h01, 8'h11);
    push_cmd(1'b0, 8'h22, 8'h99);
    push_cmd(1'b1, 8'h33, 8'h44);
    push_cmd(1'b0, 8'h55, 8'h00);
    @(negedge clock);
    check("full_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    push_cmd(1'b1, 8'h66, 8'h77);
    wait_idle(3000);
    check("rsp_count", n_rsp, 32'd7);
    check("err_low", {31'd0, err}, 32'd0);

    // reset during WAIT_DONE with two queued
    push_cmd(1'b1, 8'h70, 8'h01);
    push_cmd(1'b0, 8'h71, 8'h02);
    push_cmd(1'b1, 8'h72, 8'h03);
    n = 0;
    while (dbg_state != 3'd3 && n < 200) begin @(negedge clock); n++; end
    check("reach_wait_done", {29'd0, dbg_state}, 32'd3);
    @(negedge clock);
    #2 n_reset = 1'b0;
    #1 reset_check("midreset");
    exp_q.delete();
    starts_at_rst = n_starts;
    rsp_at_rst = n_rsp;
    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    repeat (300) @(negedge clock);
    check("post_rst_starts", n_starts, starts_at_rst);
    check("post_rst_rsp", n_rsp, rsp_at_rst);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
